instr_mem_sync: RTL and testbench

//  Synchronous, parametrised instruction memory with a fetch handshake. Replaces the

---
 rtl/instr_mem_sync_pkg.sv | 22 ++
 rtl/instr_mem_sync_if.sv | 35 +++
 rtl/instr_mem_sync_fetch_q.sv | 56 +++++
 rtl/instr_mem_sync.sv | 107 ++++++++++
 tb/tb_instr_mem_sync.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_mem_sync_pkg.sv
// Shared types for the synchronous instruction memory: fault codes, the NOP word
// and the reference layout of one fetched entry.
package instr_mem_pkg;

    localparam int IMEM_DATA_W = 16;
    localparam int IMEM_ADDR_W = 16;

    typedef enum logic [1:0] {
        FLT_NONE  = 2'd0,
        FLT_RANGE = 2'd1,
        FLT_ALIGN = 2'd2
    } fault_e;

    localparam logic [IMEM_DATA_W-1:0] NOP_INSTR = '0;

    typedef struct packed {
        logic [IMEM_DATA_W-1:0] instr;
        logic [IMEM_ADDR_W-1:0] pc;
        fault_e                 fault;
    } fetch_entry_t;

endpackage

// File: rtl/instr_mem_sync_if.sv
// Fetch, delivery and program-load signals between the fetch stage (master)
// and the instruction memory (slave).
interface instr_mem_sync_if
    import instr_mem_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 16
);
    localparam int AW = $clog2(DEPTH);

    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_pc;
    logic              fetch_ready;
    logic              flush;
    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    fault_e            instr_fault;
    logic              prog_we;
    logic [AW-1:0]     prog_addr;
    logic [DATA_W-1:0] prog_data;

    modport master (
        output fetch_req, fetch_pc, flush, instr_ready, prog_we, prog_addr, prog_data,
        input  fetch_ready, instr_valid, instr, instr_pc, instr_fault
    );

    modport slave (
        input  fetch_req, fetch_pc, flush, instr_ready, prog_we, prog_addr, prog_data,
        output fetch_ready, instr_valid, instr, instr_pc, instr_fault
    );

endinterface

// File: rtl/instr_mem_sync_fetch_q.sv
// Two-entry output FIFO for fetched instructions. slot0 is always the head, so the
// head is a plain register and holds steady while the consumer stalls.
module instr_fetch_q
    import instr_mem_pkg::*;
#(
    parameter type entry_t = fetch_entry_t
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       push,
    input  entry_t     push_data,
    input  logic       pop,
    output entry_t     head,
    output logic [1:0] count
);

    entry_t slot0;
    entry_t slot1;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0 <= '0;
            slot1 <= '0;
            count <= 2'd0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) slot0 <= push_data;
                    else               slot1 <= push_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    slot0 <= slot1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // Simultaneous push/pop: occupancy is unchanged, contents shift.
                    if (count == 2'd1) begin
                        slot0 <= push_data;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head = slot0;

endmodule

// File: rtl/instr_mem_sync.sv
// Synchronous instruction memory with fetch handshake: registered read (S1), two-entry
// output queue with S1 bypass for 1-cycle latency, flush, and PC fault reporting.
module instr_mem_sync
    import instr_mem_pkg::*;
#(
    parameter int    DATA_W    = 16,
    parameter int    ADDR_W    = 16,
    parameter int    DEPTH     = 16,
    parameter string INIT_FILE = ""
) (
    input logic              clk,
    input logic              rst_n,
    instr_mem_sync_if.slave  bus
);

    localparam int                AW         = $clog2(DEPTH);
    localparam int                OFF        = $clog2(DATA_W / 8);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((DATA_W / 8) - 1);
    localparam logic [63:0]       MEM_BYTES  = 64'(DEPTH) * 64'(DATA_W / 8);

    // Entry layout sized to this instance rather than the package defaults.
    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [ADDR_W-1:0] pc;
        fault_e            fault;
    } q_entry_t;

    logic [DATA_W-1:0] mem [DEPTH];

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'(NOP_INSTR);
    end

    // NOTE: the array has no reset branch; program contents survive rst_n, only writes under reset are dropped.
    always_ff @(posedge clk) begin
        if (bus.prog_we && rst_n) mem[bus.prog_addr] <= bus.prog_data;
    end

    fault_e        pc_fault;
    logic [AW-1:0] rd_idx;

    assign rd_idx = bus.fetch_pc[OFF +: AW];

    // NOTE: default assigned first so no path through this block leaves pc_fault unassigned (no latch).
    always_comb begin
        pc_fault = FLT_NONE;
        if ((bus.fetch_pc & ALIGN_MASK) != '0)       pc_fault = FLT_ALIGN;
        else if (64'(bus.fetch_pc) >= MEM_BYTES)     pc_fault = FLT_RANGE;
    end

    q_entry_t   s1;
    logic       s1_valid;
    q_entry_t   q_head;
    logic [1:0] q_count;
    logic       head_from_q;
    logic       fetch_ready;
    logic       accept;
    logic       pop;
    logic       q_push;
    logic       q_pop;
    q_entry_t   out_entry;

    // Outstanding fetches (queued + in S1) never exceed the queue depth.
    assign fetch_ready = !bus.flush && ((q_count + {1'b0, s1_valid}) < 2'd2);
    assign accept      = bus.fetch_req && fetch_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1       <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1.instr <= (pc_fault == FLT_NONE) ? mem[rd_idx] : DATA_W'(NOP_INSTR);
                s1.pc    <= bus.fetch_pc;
                s1.fault <= pc_fault;
            end
        end
    end

    // S1 is presented directly when the queue is empty; otherwise it drains into the queue.
    assign head_from_q = (q_count != 2'd0);
    assign out_entry   = head_from_q ? q_head : s1;
    assign pop         = bus.instr_valid && bus.instr_ready;
    assign q_pop       = pop && head_from_q;
    assign q_push      = s1_valid && !(pop && !head_from_q);

    instr_fetch_q #(
        .entry_t (q_entry_t)
    ) u_fetch_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (bus.flush),
        .push      (q_push),
        .push_data (s1),
        .pop       (q_pop),
        .head      (q_head),
        .count     (q_count)
    );

    assign bus.fetch_ready = fetch_ready;
    assign bus.instr_valid = head_from_q || s1_valid;
    assign bus.instr       = out_entry.instr;
    assign bus.instr_pc    = out_entry.pc;
    assign bus.instr_fault = out_entry.fault;

endmodule

// File: tb/tb_instr_mem_sync.sv
// Directed and randomized checks of instr_mem_sync against a queue-based model of
// outstanding fetches and a flat model of the instruction array.
module tb_instr_mem_sync;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc;
        logic [1:0]  fault;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    logic [15:0] model_mem [16];
    exp_t        exp_q[$];
    exp_t        delivered[$];
    bit          last_accept;

    instr_mem_sync_if #(.DATA_W(16), .ADDR_W(16), .DEPTH(16)) bus();

    instr_mem_sync #(
        .DATA_W    (16),
        .ADDR_W    (16),
        .DEPTH     (16),
        .INIT_FILE ("")
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Byte PC -> expected entry, straight from the address map: 2-byte words, 32 bytes.
    function automatic exp_t model_fetch(input logic [15:0] pc);
        exp_t e;
        e.pc = pc;
        if (pc % 2 != 0)  e.fault = 2'd2;
        else if (pc >= 32) e.fault = 2'd1;
        else               e.fault = 2'd0;
        e.instr = (e.fault == 2'd0) ? model_mem[pc / 2] : 16'h0000;
        return e;
    endfunction

    task automatic tick();
        bit   accept;
        bit   do_pop;
        exp_t e;
        @(negedge clk);
        check("fetch_ready", bus.fetch_ready, !bus.flush && exp_q.size() < 2);
        check("instr_valid", bus.instr_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            check("instr", bus.instr, exp_q[0].instr);
            check("instr_pc", bus.instr_pc, exp_q[0].pc);
            check("instr_fault", bus.instr_fault, exp_q[0].fault);
        end
        accept = bus.fetch_req && !bus.flush && exp_q.size() < 2;
        do_pop = exp_q.size() != 0 && bus.instr_ready;
        if (do_pop) begin
            e.instr = bus.instr;
            e.pc    = bus.instr_pc;
            e.fault = bus.instr_fault;
            delivered.push_back(e);
        end
        @(posedge clk);
        if (rst_n) begin
            if (bus.flush) begin
                exp_q.delete();
            end else begin
                if (do_pop) void'(exp_q.pop_front());
                if (accept) exp_q.push_back(model_fetch(bus.fetch_pc));
            end
            if (bus.prog_we) model_mem[bus.prog_addr] = bus.prog_data;
        end
        last_accept = accept;
        #1;
    endtask

    task automatic fetch(input logic [15:0] pc);
        bus.fetch_req = 1'b1;
        bus.fetch_pc  = pc;
        last_accept   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (last_accept) break;
        end
        check("fetch_accepted", last_accept, 1'b1);
        bus.fetch_req = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.fetch_req = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        logic [15:0] init_words [4];
        logic [15:0] pc;
        init_words[0] = 16'h8080;
        init_words[1] = 16'hE101;
        init_words[2] = 16'h0530;
        init_words[3] = 16'h0420;

        bus.fetch_req   = 1'b0;
        bus.fetch_pc    = '0;
        bus.flush       = 1'b0;
        bus.instr_ready = 1'b0;
        bus.prog_we     = 1'b0;
        bus.prog_addr   = '0;
        bus.prog_data   = '0;
        for (int i = 0; i < 16; i++) model_mem[i] = 16'h0000;

        // Reset state
        #1;
        check("rst_fetch_ready", bus.fetch_ready, 1'b1);
        check("rst_instr_valid", bus.instr_valid, 1'b0);
        check("rst_instr", bus.instr, 16'h0000);
        check("rst_instr_pc", bus.instr_pc, 16'h0000);
        check("rst_instr_fault", bus.instr_fault, 2'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Program load: fixed words 0..3, random words 4..15
        for (int i = 0; i < 16; i++) begin
            bus.prog_we   = 1'b1;
            bus.prog_addr = 4'(i);
            bus.prog_data = (i < 4) ? init_words[i] : 16'($urandom);
            tick();
        end
        bus.prog_we = 1'b0;

        // 1: back-to-back fetches with consumer always ready
        bus.instr_ready = 1'b1;
        delivered.delete();
        fetch(16'd0); fetch(16'd2); fetch(16'd4); fetch(16'd6);
        idle(2);
        check("t1_count", delivered.size(), 4);
        for (int i = 0; i < 4 && i < delivered.size(); i++) begin
            check("t1_instr", delivered[i].instr, init_words[i]);
            check("t1_pc", delivered[i].pc, 32'(2 * i));
            check("t1_fault", delivered[i].fault, 2'd0);
        end

        // 2: backpressure limits outstanding fetches to two
        bus.instr_ready = 1'b0;
        delivered.delete();
        fetch(16'd0); fetch(16'd2);
        bus.fetch_req = 1'b1;
        bus.fetch_pc  = 16'd4;
        tick(); tick();
        check("t2_ready_low", bus.fetch_ready, 1'b0);
        check("t2_head_hold", bus.instr, 16'h8080);
        bus.instr_ready = 1'b1;
        fetch(16'd4);
        idle(3);
        check("t2_count", delivered.size(), 3);
        if (delivered.size() == 3) begin
            check("t2_order0", delivered[0].instr, 16'h8080);
            check("t2_order1", delivered[1].instr, 16'hE101);
            check("t2_order2", delivered[2].instr, 16'h0530);
        end

        // 3: range, alignment, and last valid word
        delivered.delete();
        fetch(16'd32); fetch(16'd3); fetch(16'd30);
        idle(2);
        check("t3_count", delivered.size(), 3);
        if (delivered.size() == 3) begin
            check("t3_range_fault", delivered[0].fault, 2'd1);
            check("t3_range_instr", delivered[0].instr, 16'h0000);
            check("t3_align_fault", delivered[1].fault, 2'd2);
            check("t3_align_instr", delivered[1].instr, 16'h0000);
            check("t3_last_fault", delivered[2].fault, 2'd0);
            check("t3_last_instr", delivered[2].instr, model_mem[15]);
        end

        // 4: write/read collision returns the old word
        delivered.delete();
        bus.prog_we   = 1'b1;
        bus.prog_addr = 4'd2;
        bus.prog_data = 16'hBEEF;
        fetch(16'd4);
        bus.prog_we = 1'b0;
        fetch(16'd4);
        idle(2);
        check("t4_count", delivered.size(), 2);
        if (delivered.size() == 2) begin
            check("t4_old_word", delivered[0].instr, 16'h0530);
            check("t4_new_word", delivered[1].instr, 16'hBEEF);
        end

        // 5: flush with two outstanding; request in flush cycle is dropped
        bus.instr_ready = 1'b0;
        fetch(16'd0); fetch(16'd2);
        bus.flush     = 1'b1;
        bus.fetch_req = 1'b1;
        bus.fetch_pc  = 16'd6;
        tick();
        bus.flush     = 1'b0;
        bus.fetch_req = 1'b0;
        check("t5_valid_after_flush", bus.instr_valid, 1'b0);
        bus.instr_ready = 1'b1;
        delivered.delete();
        fetch(16'd0);
        idle(2);
        check("t5_count", delivered.size(), 1);
        if (delivered.size() == 1) check("t5_instr", delivered[0].instr, 16'h8080);

        // 6: asynchronous reset mid-operation; array write under reset discarded
        bus.instr_ready = 1'b0;
        fetch(16'd0); fetch(16'd4);
        #2;
        rst_n         = 1'b0;
        bus.prog_we   = 1'b1;
        bus.prog_addr = 4'd1;
        bus.prog_data = 16'hDEAD;
        #1;
        exp_q.delete();
        check("t6_valid_async", bus.instr_valid, 1'b0);
        check("t6_ready_async", bus.fetch_ready, 1'b1);
        check("t6_instr_async", bus.instr, 16'h0000);
        check("t6_pc_async", bus.instr_pc, 16'h0000);
        @(posedge clk);
        #1 bus.prog_we = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        bus.instr_ready = 1'b1;
        delivered.delete();
        fetch(16'd2);
        idle(2);
        check("t6_count", delivered.size(), 1);
        if (delivered.size() == 1) check("t6_retained", delivered[0].instr, 16'hE101);

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            int sel;
            sel = $urandom_range(0, 7);
            if (sel <= 5)      pc = 16'($urandom_range(0, 15) * 2);
            else if (sel == 6) pc = 16'($urandom_range(0, 15) * 2 + 1);
            else               pc = 16'($urandom_range(32, 65535));
            bus.fetch_req   = ($urandom_range(0, 3) != 0);
            bus.fetch_pc    = pc;
            bus.instr_ready = ($urandom_range(0, 9) < 7);
            bus.flush       = ($urandom_range(0, 19) == 0);
            bus.prog_we     = ($urandom_range(0, 7) == 0);
            bus.prog_addr   = 4'($urandom_range(0, 15));
            bus.prog_data   = 16'($urandom);
            tick();
        end
        bus.flush       = 1'b0;
        bus.prog_we     = 1'b0;
        bus.instr_ready = 1'b1;
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
